// File: rtl/imem_pkg.sv
`default_nettype none
// imem_pkg -- shared constants and pipeline-entry type for the instruction-memory responder.
// rev 1.0
package imem_pkg;

   localparam int INSTR_W = 32;
   // Widest supported address; pipeline entries carry addresses zero-extended to this width.
   localparam int ADDR_W  = 64;

   localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] addr;
      logic              err;
   } pipe_entry_t;

endpackage
`default_nettype wire

// File: rtl/imem_array.sv
`default_nettype none
// imem_array -- instruction storage, 1 read + 1 write port, read returns pre-write contents.
// rev 1.0
module imem_array
   import imem_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic               clk,
   input  logic [AW-1:0]      rd_idx_i,
   output logic [INSTR_W-1:0] rd_data_o,
   input  logic               wr_en_i,
   input  logic [AW-1:0]      wr_idx_i,
   input  logic [INSTR_W-1:0] wr_data_i
);

   logic [INSTR_W-1:0] mem_q [DEPTH];

   // The read is sampled by the pipeline on the same edge that commits a write,
   // so a same-word read in that cycle sees the old contents.
   assign rd_data_o = mem_q[rd_idx_i];

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_idx_i] <= wr_data_i;
      end
   end

endmodule
`default_nettype wire

// File: rtl/imem_responder.sv
`default_nettype none
// imem_responder -- fixed-latency instruction fetch responder with flush, stall and preload.
// rev 1.0
module imem_responder
   import imem_pkg::*;
#(
   parameter int N       = 64,
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid_i,
   input  logic [N-1:0]       req_addr_i,
   input  logic               flush_i,
   input  logic               stall_i,
   input  logic               wr_en_i,
   input  logic [N-1:0]       wr_addr_i,
   input  logic [INSTR_W-1:0] wr_data_i,
   output logic               rsp_valid_o,
   output logic [INSTR_W-1:0] rsp_instr_o,
   output logic [N-1:0]       rsp_addr_o,
   output logic               rsp_err_o,
   output logic [2:0]         inflight_o
);

   localparam int           AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [N-3:0] DEPTH_W = (N-2)'(DEPTH);

   logic [N-3:0]       req_widx;
   logic [N-3:0]       wr_widx;
   logic               req_in_range;
   logic               wr_in_range;
   logic               req_err;
   logic               advance;
   logic [AW-1:0]      rd_idx;
   logic [INSTR_W-1:0] rd_data;
   logic               unused_wr_lsb;

   assign req_widx      = req_addr_i[N-1:2];
   assign wr_widx       = wr_addr_i[N-1:2];
   assign req_in_range  = (req_widx < DEPTH_W);
   assign wr_in_range   = (wr_widx < DEPTH_W);
   assign req_err       = (req_addr_i[1:0] != 2'b00) || !req_in_range;
   assign advance       = flush_i || !stall_i;
   assign rd_idx        = req_in_range ? req_widx[AW-1:0] : '0;
   assign unused_wr_lsb = ^wr_addr_i[1:0];

   imem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk       (clk),
      .rd_idx_i  (rd_idx),
      .rd_data_o (rd_data),
      .wr_en_i   (wr_en_i && wr_in_range),
      .wr_idx_i  (wr_widx[AW-1:0]),
      .wr_data_i (wr_data_i)
   );

   pipe_entry_t [LATENCY-1:0]        pipe_q, pipe_d;
   logic [LATENCY-1:0][INSTR_W-1:0] instr_q, instr_d;

   // Stage 0 always takes the presented request; a flush empties every later stage.
   always_comb begin
      pipe_d  = pipe_q;
      instr_d = instr_q;
      if (advance) begin
         pipe_d[0]  = '{valid: req_valid_i, addr: ADDR_W'(req_addr_i), err: req_err};
         instr_d[0] = rd_data;
         for (int k = 1; k < LATENCY; k++) begin
            if (flush_i) begin
               pipe_d[k] = '0;
            end else begin
               pipe_d[k] = pipe_q[k-1];
            end
            instr_d[k] = instr_q[k-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_q  <= '0;
         instr_q <= '0;
      end else begin
         pipe_q  <= pipe_d;
         instr_q <= instr_d;
      end
   end

   pipe_entry_t last;
   logic [2:0]  inflight_cnt;

   assign last = pipe_q[LATENCY-1];

   always_comb begin
      inflight_cnt = '0;
      for (int k = 0; k < LATENCY; k++) begin
         inflight_cnt = inflight_cnt + {2'b00, pipe_q[k].valid};
      end
   end

   assign rsp_valid_o = last.valid;
   assign rsp_err_o   = last.valid && last.err;
   assign rsp_addr_o  = last.valid ? N'(last.addr) : '0;
   assign rsp_instr_o = !last.valid ? '0 : (last.err ? NOP : instr_q[LATENCY-1]);
   assign inflight_o  = inflight_cnt;

endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// tb_imem_responder -- directed stimulus with a queue-based response scoreboard.
// rev 1.0
`timescale 1ns/1ps
module tb_imem_responder;

   localparam int          N       = 64;
   localparam int          DEPTH   = 64;
   localparam int          LATENCY = 2;
   localparam logic [31:0] NOP     = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req_valid_i = 1'b0;
   logic [63:0] req_addr_i = '0;
   logic        flush_i = 1'b0;
   logic        stall_i = 1'b0;
   logic        wr_en_i = 1'b0;
   logic [63:0] wr_addr_i = '0;
   logic [31:0] wr_data_i = '0;
   logic        rsp_valid_o;
   logic [31:0] rsp_instr_o;
   logic [63:0] rsp_addr_o;
   logic        rsp_err_o;
   logic [2:0]  inflight_o;

   imem_responder #(.N(N), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid_i (req_valid_i),
      .req_addr_i  (req_addr_i),
      .flush_i     (flush_i),
      .stall_i     (stall_i),
      .wr_en_i     (wr_en_i),
      .wr_addr_i   (wr_addr_i),
      .wr_data_i   (wr_data_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_instr_o (rsp_instr_o),
      .rsp_addr_o  (rsp_addr_o),
      .rsp_err_o   (rsp_err_o),
      .inflight_o  (inflight_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] addr;
      logic [31:0] instr;
      logic        err;
      int          due;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   logic adv_q    = 1'b1;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      adv_q <= flush_i | ~stall_i;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // A response is new only in the cycle after an edge that moved the pipeline.
   always @(negedge clk) begin
      exp_t e;
      if (rsp_valid_o && adv_q) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rsp: got addr 0x%0h instr 0x%0h, expected no response (cycle %0d)",
                     rsp_addr_o, rsp_instr_o, cyc);
         end else begin
            e = exp_q.pop_front();
            chk("rsp_addr",  rsp_addr_o, e.addr);
            chk("rsp_instr", 64'(rsp_instr_o), 64'(e.instr));
            chk("rsp_err",   64'(rsp_err_o), 64'(e.err));
            chk("rsp_cycle", 64'(cyc), 64'(e.due));
         end
      end else if (!rsp_valid_o) begin
         chk("idle_instr_zero", 64'(rsp_instr_o), 64'h0);
         chk("idle_addr_zero",  rsp_addr_o, 64'h0);
         chk("idle_err_zero",   64'(rsp_err_o), 64'h0);
      end
   end

   task automatic drive(input logic v, input logic [63:0] a,
                        input logic st = 1'b0, input logic fl = 1'b0);
      @(posedge clk);
      #1;
      req_valid_i = v;
      req_addr_i  = a;
      stall_i     = st;
      flush_i     = fl;
      wr_en_i     = 1'b0;
   endtask

   task automatic wr(input logic [63:0] a, input logic [31:0] d);
      wr_en_i   = 1'b1;
      wr_addr_i = a;
      wr_data_i = d;
   endtask

   task automatic push(input logic [63:0] a, input logic [31:0] d, input logic e, input int due);
      exp_q.push_back('{addr: a, instr: d, err: e, due: due});
   endtask

   task automatic mid();
      @(negedge clk);
      #1;
   endtask

   initial begin
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      mid();
      chk("reset_valid",    64'(rsp_valid_o), 64'h0);
      chk("reset_inflight", 64'(inflight_o), 64'h0);
      chk("reset_instr",    64'(rsp_instr_o), 64'h0);
      chk("reset_addr",     rsp_addr_o, 64'h0);
      chk("reset_err",      64'(rsp_err_o), 64'h0);
      drive(1'b0, 64'h0);
      rst_n = 1'b1;

      // Preload, including a write under stall and a dropped out-of-range write under flush.
      drive(1'b0, 64'h0);             wr(64'h0,   32'hAAAA_0001);
      drive(1'b0, 64'h0);             wr(64'h4,   32'hBBBB_0002);
      drive(1'b0, 64'h0);             wr(64'h8,   32'hDEAD_0003);
      drive(1'b0, 64'h0, 1'b1, 1'b0); wr(64'h40,  32'h4040_4040);
      drive(1'b0, 64'h0, 1'b0, 1'b1); wr(64'h100, 32'hBAD0_BAD0);

      // Back-to-back good reads.
      drive(1'b1, 64'h0); push(64'h0, 32'hAAAA_0001, 1'b0, cyc + LATENCY);
      drive(1'b1, 64'h4); push(64'h4, 32'hBBBB_0002, 1'b0, cyc + LATENCY);
      repeat (3) drive(1'b0, 64'h0);

      // Misaligned and out-of-range requests.
      drive(1'b1, 64'h2);   push(64'h2,   NOP, 1'b1, cyc + LATENCY);
      drive(1'b0, 64'h0);
      drive(1'b1, 64'h100); push(64'h100, NOP, 1'b1, cyc + LATENCY);
      drive(1'b1, 64'h103); push(64'h103, NOP, 1'b1, cyc + LATENCY);
      repeat (3) drive(1'b0, 64'h0);

      // Same-word read and write in one cycle, then a repeat read.
      drive(1'b1, 64'h8); wr(64'h8, 32'h1234_5678); push(64'h8, 32'hDEAD_0003, 1'b0, cyc + LATENCY);
      drive(1'b1, 64'h8); push(64'h8, 32'h1234_5678, 1'b0, cyc + LATENCY);
      repeat (3) drive(1'b0, 64'h0);

      // Three requests, then a flush carrying 0x40 while stall is also high.
      drive(1'b1, 64'h0); push(64'h0, 32'hAAAA_0001, 1'b0, cyc + LATENCY);
      drive(1'b1, 64'h4); push(64'h4, 32'hBBBB_0002, 1'b0, cyc + LATENCY);
      drive(1'b1, 64'h0); push(64'h0, 32'hAAAA_0001, 1'b0, cyc + LATENCY);
      drive(1'b1, 64'h40, 1'b1, 1'b1);
      mid();
      exp_q.delete();
      push(64'h40, 32'h4040_4040, 1'b0, cyc + LATENCY);
      drive(1'b0, 64'h0);
      mid();
      chk("inflight_after_flush", 64'(inflight_o), 64'h1);
      repeat (3) drive(1'b0, 64'h0);

      // Flush with no request empties the pipeline.
      drive(1'b1, 64'h4); push(64'h4, 32'hBBBB_0002, 1'b0, cyc + LATENCY);
      drive(1'b0, 64'h0, 1'b0, 1'b1);
      mid();
      chk("inflight_before_flush", 64'(inflight_o), 64'h1);
      exp_q.delete();
      drive(1'b0, 64'h0);
      mid();
      chk("inflight_flush_empty", 64'(inflight_o), 64'h0);
      repeat (2) drive(1'b0, 64'h0);

      // Stall for three cycles with a response on the output; stalled requests are ignored.
      drive(1'b1, 64'h0); push(64'h0, 32'hAAAA_0001, 1'b0, cyc + LATENCY);
      drive(1'b1, 64'h4); push(64'h4, 32'hBBBB_0002, 1'b0, cyc + LATENCY + 3);
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive(logic'(i < 2), 64'hC, logic'(i < 2), 1'b0);
         mid();
         chk("stall_hold_valid",    64'(rsp_valid_o), 64'h1);
         chk("stall_hold_instr",    64'(rsp_instr_o), 64'hAAAA_0001);
         chk("stall_hold_addr",     rsp_addr_o, 64'h0);
         chk("stall_hold_inflight", 64'(inflight_o), 64'h2);
      end
      repeat (3) drive(1'b0, 64'h0);

      // Asynchronous reset with two entries in flight.
      drive(1'b1, 64'h0); push(64'h0, 32'hAAAA_0001, 1'b0, cyc + LATENCY);
      drive(1'b1, 64'h4); push(64'h4, 32'hBBBB_0002, 1'b0, cyc + LATENCY);
      drive(1'b0, 64'h0);
      #2;
      chk("inflight_before_reset", 64'(inflight_o), 64'h2);
      rst_n = 1'b0;
      #1;
      chk("async_reset_valid",    64'(rsp_valid_o), 64'h0);
      chk("async_reset_inflight", 64'(inflight_o), 64'h0);
      chk("async_reset_instr",    64'(rsp_instr_o), 64'h0);
      exp_q.delete();
      repeat (2) drive(1'b0, 64'h0);
      rst_n = 1'b1;
      repeat (5) drive(1'b0, 64'h0);

      // Memory contents survive reset.
      drive(1'b1, 64'h4); push(64'h4, 32'hBBBB_0002, 1'b0, cyc + LATENCY);
      drive(1'b0, 64'h0);

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
         @(posedge clk);
      end
      repeat (2) @(posedge clk);
      chk("queue_drained", 64'(exp_q.size()), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
